// File: rtl/game_rom_pkg.sv
// Shared types and width helpers for the cartridge-memory bridge.
package game_rom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int lane_w(input int avs_w, input int mem_w);
    return $clog2(avs_w / mem_w);
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/game_rom_bridge.sv
// Avalon-MM slave that serialises 32-bit bus words into byte cycles on NUM_CH cartridge memories.
// state   | meaning
// ST_IDLE | waiting for a command; hold blocks acceptance
// ST_WR   | one write cycle per lane, disabled lanes still take their cycle
// ST_RD   | per lane: issue cycle plus READ_LATENCY wait cycles, capture in the last
// ST_DONE | waitrequest low for one cycle
module game_rom_bridge
  import game_rom_pkg::*;
#(
  parameter  int AVS_DATA_W   = 32,
  parameter  int MEM_DATA_W   = 8,
  parameter  int MEM_ADDR_W   = 16,
  parameter  int NUM_CH       = 2,
  parameter  int READ_LATENCY = 2,
  localparam int LANES        = AVS_DATA_W / MEM_DATA_W,
  localparam int LANE_W       = lane_w(AVS_DATA_W, MEM_DATA_W),
  localparam int CH_W         = ch_w(NUM_CH),
  localparam int AVS_ADDR_W   = CH_W + MEM_ADDR_W - LANE_W
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic [AVS_ADDR_W-1:0]        avs_address,
  input  logic                         avs_write,
  input  logic [AVS_DATA_W-1:0]        avs_writedata,
  input  logic [LANES-1:0]             avs_byteenable,
  input  logic                         avs_read,
  output logic [AVS_DATA_W-1:0]        avs_readdata,
  output logic                         avs_waitrequest,
  input  logic                         hold,
  output logic [MEM_ADDR_W-1:0]        mem_addr,
  output logic [MEM_DATA_W-1:0]        mem_wdata,
  output logic [NUM_CH-1:0]            mem_we,
  output logic [NUM_CH-1:0]            mem_re,
  input  logic [NUM_CH*MEM_DATA_W-1:0] mem_rdata,
  output logic                         busy
);

  localparam int WORD_W = MEM_ADDR_W - LANE_W;
  localparam int LAT_W  = $clog2(READ_LATENCY + 1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(READ_LATENCY);

  state_e                  state_q, state_d;
  logic [LANE_W-1:0]       lane_q, lane_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [WORD_W-1:0]       word_q, word_d;
  logic [AVS_DATA_W-1:0]   data_q, data_d;
  logic [LANES-1:0]        be_q, be_d;
  logic [AVS_DATA_W-1:0]   rdata_q, rdata_d;
  logic [MEM_ADDR_W-1:0]   addr_q, addr_d;
  logic [MEM_DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_CH-1:0]       we_q, we_d;
  logic [NUM_CH-1:0]       re_q, re_d;
  logic [MEM_DATA_W-1:0]   rd_byte;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    lat_d   = lat_q;
    ch_d    = ch_q;
    word_d  = word_q;
    data_d  = data_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = '0;
    re_d    = '0;
    rd_byte = '0;

    // Out-of-range channels never match, so their reads return zero.
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == CH_W'(c)) rd_byte = mem_rdata[c*MEM_DATA_W +: MEM_DATA_W];
    end

    case (state_q)
      ST_IDLE: begin
        if (!hold && (avs_write || avs_read)) begin
          ch_d   = avs_address[AVS_ADDR_W-1 -: CH_W];
          word_d = avs_address[WORD_W-1:0];
          lane_d = '0;
          if (avs_write) begin
            data_d  = avs_writedata;
            be_d    = avs_byteenable;
            state_d = ST_WR;
          end else begin
            lat_d   = LAT_LOAD;
            rdata_d = '0;
            state_d = ST_RD;
          end
        end
      end
      ST_WR: begin
        if (lane_q == LAST_LANE) state_d = ST_DONE;
        else                     lane_d  = lane_q + 1'b1;
      end
      ST_RD: begin
        if (lat_q == '0) begin
          rdata_d[int'(lane_q)*MEM_DATA_W +: MEM_DATA_W] = rd_byte;
          if (lane_q == LAST_LANE) begin
            state_d = ST_DONE;
          end else begin
            lane_d = lane_q + 1'b1;
            lat_d  = LAT_LOAD;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Memory-side outputs are registered from the next state so each lane's
    // strobe appears in the cycle the FSM spends on that lane.
    if (state_d == ST_WR) begin
      addr_d  = {word_d, lane_d};
      wdata_d = data_d[int'(lane_d)*MEM_DATA_W +: MEM_DATA_W];
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_d == CH_W'(c)) we_d[c] = be_d[lane_d];
      end
    end else if (state_d == ST_RD) begin
      addr_d = {word_d, lane_d};
      if (lat_d == LAT_LOAD) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_d == CH_W'(c)) re_d[c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
      lat_q   <= '0;
      ch_q    <= '0;
      word_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      re_q    <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      lat_q   <= lat_d;
      ch_q    <= ch_d;
      word_q  <= word_d;
      data_q  <= data_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
    end
  end

  assign avs_readdata    = rdata_q;
  assign avs_waitrequest = (state_q != ST_DONE);
  assign busy            = (state_q != ST_IDLE);
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign mem_we          = we_q;
  assign mem_re          = re_q;

endmodule

// File: tb/tb_game_rom_bridge.sv
// Scoreboard bench for game_rom_bridge: directed commands push expected strobes and responses,
// a negedge monitor pops and compares. Three channels are built so channel 3 is out of range.
module tb_game_rom_bridge;

  localparam int NCH = 3;

  logic               clk_clk = 1'b0;
  logic               reset_reset = 1'b1;
  logic [15:0]        avs_address = '0;
  logic               avs_write = 1'b0;
  logic [31:0]        avs_writedata = '0;
  logic [3:0]         avs_byteenable = '0;
  logic               avs_read = 1'b0;
  logic [31:0]        avs_readdata;
  logic               avs_waitrequest;
  logic               hold = 1'b0;
  logic [15:0]        mem_addr;
  logic [7:0]         mem_wdata;
  logic [NCH-1:0]     mem_we;
  logic [NCH-1:0]     mem_re;
  logic [NCH*8-1:0]   mem_rdata;
  logic               busy;

  game_rom_bridge #(.NUM_CH(NCH)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_byteenable(avs_byteenable), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_waitrequest(avs_waitrequest), .hold(hold),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk_clk = ~clk_clk;

  int cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  // Byte memories with a two-stage read pipeline (latency 2).
  logic       mem_clr = 1'b1;
  logic [7:0] mem [NCH][256];
  logic [7:0] s1 [NCH];
  logic [7:0] s2 [NCH];
  always @(posedge clk_clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (mem_clr) begin
        for (int a = 0; a < 256; a++) mem[c][a] <= 8'h00;
      end else if (mem_we[c]) begin
        mem[c][mem_addr[7:0]] <= mem_wdata;
      end
      s1[c] <= mem_re[c] ? mem[c][mem_addr[7:0]] : 8'h00;
      s2[c] <= s1[c];
    end
  end
  assign mem_rdata = {s2[2], s2[1], s2[0]};

  typedef struct {
    logic [2:0]  we;
    logic [2:0]  re;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          cyc;
  } stb_t;

  typedef struct {
    bit          is_rd;
    logic [31:0] rdata;
    int          start;
    int          lat;
    int          tag;
  } rsp_t;

  stb_t stb_q[$];
  rsp_t rsp_q[$];
  stb_t se;
  rsp_t rr;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   rd_too = 1'b0;

  always @(negedge clk_clk) begin
    if (|mem_we || |mem_re) begin
      n_cmp++;
      if (stb_q.size() == 0) begin
        n_err++;
        $display("FAIL strobe_unexpected: got we=%b re=%b addr=%h at cycle %0d, required no strobe",
                 mem_we, mem_re, mem_addr, cyc);
      end else begin
        se = stb_q.pop_front();
        if (mem_we !== se.we || mem_re !== se.re || mem_addr !== se.addr ||
            (|se.we && mem_wdata !== se.wdata) || cyc != se.cyc) begin
          n_err++;
          $display("FAIL strobe: got we=%b re=%b addr=%h wdata=%h cyc=%0d, required we=%b re=%b addr=%h wdata=%h cyc=%0d",
                   mem_we, mem_re, mem_addr, mem_wdata, cyc, se.we, se.re, se.addr, se.wdata, se.cyc);
        end
      end
    end
    if (!avs_waitrequest) begin
      n_cmp++;
      if (rsp_q.size() == 0) begin
        n_err++;
        $display("FAIL response_unexpected: waitrequest low at cycle %0d, required high", cyc);
      end else begin
        rr = rsp_q.pop_front();
        if ((cyc - rr.start + 1) != rr.lat || (rr.is_rd && avs_readdata !== rr.rdata)) begin
          n_err++;
          $display("FAIL response tag %0d: got latency %0d readdata %h, required latency %0d readdata %h",
                   rr.tag, cyc - rr.start + 1, avs_readdata, rr.lat, rr.is_rd ? rr.rdata : avs_readdata);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Expected strobes for the first nl lanes, plus the response when with_rsp.
  task automatic push_exp(input bit is_wr, input logic [1:0] ch, input logic [13:0] word,
                          input logic [31:0] data, input logic [3:0] be, input logic [31:0] exp_rd,
                          input int n, input int nl, input bit with_rsp, input int tag);
    for (int l = 0; l < nl; l++) begin
      stb_t s;
      if (ch < 2'd3 && (!is_wr || be[l])) begin
        s.we    = is_wr ? (3'(1) << ch) : 3'b000;
        s.re    = is_wr ? 3'b000 : (3'(1) << ch);
        s.addr  = {word, 2'(l)};
        s.wdata = is_wr ? data[l*8 +: 8] : 8'h00;
        s.cyc   = is_wr ? (n + 1 + l) : (n + 1 + l*3);
        stb_q.push_back(s);
      end
    end
    if (with_rsp)
      rsp_q.push_back('{is_rd: !is_wr, rdata: exp_rd, start: n, lat: (is_wr ? 6 : 14), tag: tag});
  endtask

  task automatic drive(input bit is_wr, input logic [1:0] ch, input logic [13:0] word,
                       input logic [31:0] data, input logic [3:0] be);
    avs_address    = {ch, word};
    avs_writedata  = data;
    avs_byteenable = be;
    avs_write      = is_wr;
    avs_read       = !is_wr | rd_too;
  endtask

  task automatic wait_done(input int tag);
    int k = 0;
    while (k < 100) begin
      @(negedge clk_clk);
      if (!avs_waitrequest) break;
      k++;
    end
    if (k >= 100) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout tag %0d: waitrequest stayed 1 for 100 cycles, required 0", tag);
    end
    @(posedge clk_clk); #1;
    avs_write = 1'b0;
    avs_read  = 1'b0;
  endtask

  task automatic do_cmd(input bit is_wr, input logic [1:0] ch, input logic [13:0] word,
                        input logic [31:0] data, input logic [3:0] be, input logic [31:0] exp_rd,
                        input int tag);
    @(posedge clk_clk); #1;
    push_exp(is_wr, ch, word, data, be, exp_rd, cyc, 4, 1'b1, tag);
    drive(is_wr, ch, word, data, be);
    wait_done(tag);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_waitrequest"}, 32'(avs_waitrequest), 32'd1);
    chk({pfx, "_readdata"},    avs_readdata,         32'd0);
    chk({pfx, "_busy"},        32'(busy),            32'd0);
    chk({pfx, "_we"},          32'(mem_we),          32'd0);
    chk({pfx, "_re"},          32'(mem_re),          32'd0);
    chk({pfx, "_addr"},        32'(mem_addr),        32'd0);
    chk({pfx, "_wdata"},       32'(mem_wdata),       32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk_clk);
    #1;
    chk_reset_outputs("reset");
    reset_reset = 1'b0;
    mem_clr     = 1'b0;

    // full-word write, sparse write, readbacks
    do_cmd(1'b1, 2'd0, 14'h0010, 32'hDDCCBBAA, 4'b1111, 32'h0, 1);
    do_cmd(1'b1, 2'd1, 14'h0020, 32'h44332211, 4'b0101, 32'h0, 2);
    do_cmd(1'b0, 2'd0, 14'h0010, 32'h0, 4'b0000, 32'hDDCCBBAA, 3);
    do_cmd(1'b0, 2'd1, 14'h0020, 32'h0, 4'b0000, 32'h00330011, 4);

    // hold blocks a pending read, release starts it the same cycle
    @(posedge clk_clk); #1;
    hold = 1'b1;
    drive(1'b0, 2'd0, 14'h0010, 32'h0, 4'b0000);
    repeat (5) begin
      @(negedge clk_clk);
      chk("hold_waitrequest", 32'(avs_waitrequest), 32'd1);
      chk("hold_busy",        32'(busy),            32'd0);
    end
    @(posedge clk_clk); #1;
    push_exp(1'b0, 2'd0, 14'h0010, 32'h0, 4'b0000, 32'hDDCCBBAA, cyc, 4, 1'b1, 5);
    hold = 1'b0;
    wait_done(5);

    // hold raised mid-write does not stop the write
    fork
      do_cmd(1'b1, 2'd0, 14'h0011, 32'h87654321, 4'b1111, 32'h0, 6);
      begin
        repeat (3) @(posedge clk_clk);
        #2 hold = 1'b1;
      end
    join
    hold = 1'b0;
    do_cmd(1'b0, 2'd0, 14'h0011, 32'h0, 4'b0000, 32'h87654321, 7);

    // write wins over simultaneous read
    rd_too = 1'b1;
    do_cmd(1'b1, 2'd0, 14'h0012, 32'h0BADF00D, 4'b1111, 32'h0, 8);
    rd_too = 1'b0;
    do_cmd(1'b0, 2'd0, 14'h0012, 32'h0, 4'b0000, 32'h0BADF00D, 9);

    // channel 3 is out of range: no strobes, normal latency, zero read data
    do_cmd(1'b1, 2'd3, 14'h0010, 32'hFFFFFFFF, 4'b1111, 32'h0, 10);
    do_cmd(1'b0, 2'd3, 14'h0010, 32'h0, 4'b0000, 32'h00000000, 11);

    // reset during lane 2 of a read
    @(posedge clk_clk); #1;
    n = cyc;
    push_exp(1'b0, 2'd0, 14'h0010, 32'h0, 4'b0000, 32'h0, n, 3, 1'b0, 12);
    drive(1'b0, 2'd0, 14'h0010, 32'h0, 4'b0000);
    repeat (8) @(posedge clk_clk);
    #1;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset_reset = 1'b1;
    #1;
    chk_reset_outputs("midrd_reset");
    avs_read = 1'b0;
    repeat (2) @(posedge clk_clk);
    #1 reset_reset = 1'b0;
    do_cmd(1'b1, 2'd1, 14'h0030, 32'hA55A3CC3, 4'b1111, 32'h0, 13);
    do_cmd(1'b0, 2'd1, 14'h0030, 32'h0, 4'b0000, 32'hA55A3CC3, 14);

    repeat (5) @(posedge clk_clk);
    #1;
    chk("queues_drained", 32'(stb_q.size() + rsp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
